// File: rtl/regfile_read_arbiter_if.sv
// Handshake bundle between requesters, the round-robin read arbiter and the
// register-file read mux. The master side is requesters plus the mux; the slave side is the arbiter.
interface regfile_read_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 10,
   parameter int ADDR_W  = 3,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      port_hold;
   logic [ADDR_W-1:0]         sel;
   logic [DATA_W-1:0]         rd_data;
   logic                      rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_data;

   modport master (
      output req_valid, req_addr, port_hold, rd_data,
      input  req_ready, sel, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req_addr, port_hold, rd_data,
      output req_ready, sel, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter for the single register-file read port: grants one
// requester per cycle, steers the mux select and returns a tagged response.
module regfile_read_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 10,
   parameter int ADDR_W  = 3,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   regfile_read_arbiter_if.slave  bus
);
   localparam int VEXT = 1 << ID_W;

   logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
   logic [ADDR_W-1:0] last_sel_q,  last_sel_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

   logic [VEXT-1:0]   valid_ext;
   logic [ADDR_W-1:0] addr_arr [VEXT];
   logic              grant;
   logic [ID_W-1:0]   winner;
   logic [ADDR_W-1:0] win_addr;
   logic [ID_W:0]     scan;

   // Widen to a power-of-two table so the ID_W-bit winner index is always in range.
   always_comb begin
      valid_ext = VEXT'(bus.req_valid);
      for (int i = 0; i < VEXT; i++) begin
         addr_arr[i] = '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
   end

   always_comb begin
      grant  = 1'b0;
      winner = '0;
      scan   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (scan >= (ID_W+1)'(NUM_REQ)) begin
            scan = scan - (ID_W+1)'(NUM_REQ);
         end
         if (!grant && !bus.port_hold && valid_ext[scan[ID_W-1:0]]) begin
            grant  = 1'b1;
            winner = scan[ID_W-1:0];
         end
      end
      win_addr = addr_arr[winner];
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      last_sel_d  = last_sel_q;
      rsp_valid_d = grant;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      if (grant) begin
         rr_ptr_d   = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
         last_sel_d = win_addr;
         rsp_id_d   = winner;
         rsp_data_d = bus.rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         last_sel_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         last_sel_q  <= last_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // With no grant the select parks on the last address so the mux input stays quiet.
   assign bus.req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
   assign bus.sel       = grant ? win_addr : last_sel_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: a queue-free behavioural model is
// checked every cycle, and literal expectations pin the directed scenarios.
module tb_regfile_read_arbiter;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_read_arbiter_if #(.NUM_REQ(NR), .DATA_W(10), .ADDR_W(3), .ID_W(2)) bus ();

   regfile_read_arbiter #(.NUM_REQ(NR), .DATA_W(10), .ADDR_W(3), .ID_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [9:0] regs [8];
   assign bus.rd_data = regs[bus.sel];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: what the arbiter must remember, in plain integers.
   bit         check_en = 1'b0;
   int         m_ptr, m_rid;
   logic [2:0] m_last;
   bit         m_rv;
   logic [9:0] m_rdata;

   function automatic logic [2:0] m_addr(input int i);
      return bus.req_addr[i*3 +: 3];
   endfunction

   function automatic int m_win();
      if (bus.port_hold) return -1;
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (m_ptr + k) % NR;
         if (bus.req_valid[i]) return i;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int w;
      if (rst) begin
         check_en = 1'b1;
         m_ptr = 0; m_last = '0; m_rv = 1'b0; m_rid = 0; m_rdata = '0;
      end else begin
         w = m_win();
         if (w >= 0) begin
            m_rv    = 1'b1;
            m_rid   = w;
            m_last  = m_addr(w);
            m_rdata = regs[m_addr(w)];
            m_ptr   = (w + 1) % NR;
         end else begin
            m_rv = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      int w;
      if (check_en) begin
         w = m_win();
         chk("m_ready", 32'(bus.req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
         chk("m_sel", 32'(bus.sel), (w >= 0) ? 32'(m_addr(w)) : 32'(m_last));
         chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
         chk("m_rsp_id", 32'(bus.rsp_id), 32'(m_rid));
         chk("m_rsp_data", 32'(bus.rsp_data), 32'(m_rdata));
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] rr_ready [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [9:0] rr_data  [4] = '{10'h011, 10'h022, 10'h033, 10'h044};

   initial begin
      regs[0] = 10'h000; regs[1] = 10'h011; regs[2] = 10'h022; regs[3] = 10'h033;
      regs[4] = 10'h044; regs[5] = 10'h2A3; regs[6] = 10'h3C6; regs[7] = 10'h1F7;
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.port_hold = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset then idle
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("idle_ready", 32'(bus.req_ready), 32'd0);
         chk("idle_sel", 32'(bus.sel), 32'd0);
         chk("idle_rsp_data", 32'(bus.rsp_data), 32'd0);
         next_cycle();
      end

      // single read of r5 by requester 2
      bus.req_valid = 4'b0100;
      bus.req_addr  = {3'd0, 3'd5, 3'd0, 3'd0};
      @(negedge clk);
      chk("single_ready", 32'(bus.req_ready), 32'b0100);
      chk("single_sel", 32'(bus.sel), 32'd5);
      next_cycle();
      bus.req_valid = '0;
      @(negedge clk);
      chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("single_rsp_id", 32'(bus.rsp_id), 32'd2);
      chk("single_rsp_data", 32'(bus.rsp_data), 32'h2A3);
      next_cycle();
      @(negedge clk);
      chk("single_after_valid", 32'(bus.rsp_valid), 32'd0);
      chk("single_after_sel", 32'(bus.sel), 32'd5);
      next_cycle();

      // pointer is at 3 now: a lone request from 3 moves it to 0
      bus.req_valid = 4'b1000;
      @(negedge clk);
      chk("lone3_ready", 32'(bus.req_ready), 32'b1000);
      next_cycle();

      // round robin with all four valid
      bus.req_valid = 4'b1111;
      bus.req_addr  = {3'd4, 3'd3, 3'd2, 3'd1};
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("rr_ready", 32'(bus.req_ready), 32'(rr_ready[c % 4]));
         if (c > 0) chk("rr_rsp_data", 32'(bus.rsp_data), 32'(rr_data[(c - 1) % 4]));
         next_cycle();
      end
      bus.req_valid = '0;
      @(negedge clk);
      chk("rr_last_rsp", 32'(bus.rsp_data), 32'h044);
      next_cycle();

      // pointer wrap: after grant to 3, requesters 1 and 3 pending
      bus.req_valid = 4'b1010;
      bus.req_addr  = {3'd7, 3'd0, 3'd6, 3'd0};
      @(negedge clk);
      chk("wrap_first", 32'(bus.req_ready), 32'b0010);
      chk("wrap_first_sel", 32'(bus.sel), 32'd6);
      next_cycle();
      bus.req_valid = 4'b1000;
      @(negedge clk);
      chk("wrap_second", 32'(bus.req_ready), 32'b1000);
      chk("wrap_rsp_data", 32'(bus.rsp_data), 32'h3C6);
      next_cycle();
      bus.req_valid = '0;
      @(negedge clk);
      chk("wrap_rsp_id", 32'(bus.rsp_id), 32'd3);
      next_cycle();

      // port_hold with 0 and 2 pending
      bus.req_valid = 4'b0101;
      bus.req_addr  = {3'd0, 3'd3, 3'd0, 3'd1};
      bus.port_hold = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("hold_ready", 32'(bus.req_ready), 32'd0);
         chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("hold_sel", 32'(bus.sel), 32'd7);
         next_cycle();
      end
      bus.port_hold = 1'b0;
      @(negedge clk);
      chk("release_ready", 32'(bus.req_ready), 32'b0001);
      chk("release_sel", 32'(bus.sel), 32'd1);
      next_cycle();
      bus.req_valid = 4'b0100;
      @(negedge clk);
      chk("release_next", 32'(bus.req_ready), 32'b0100);
      next_cycle();

      // reset lands on a cycle that grants requester 1
      bus.req_valid = 4'b0010;
      bus.req_addr  = {3'd0, 3'd0, 3'd2, 3'd4};
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 32'(bus.req_ready), 32'b0010);
      next_cycle();
      rst = 1'b0;
      bus.req_valid = 4'b0011;
      @(negedge clk);
      chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_winner", 32'(bus.req_ready), 32'b0001);
      chk("midrst_sel", 32'(bus.sel), 32'd4);
      next_cycle();
      bus.req_valid = '0;
      @(negedge clk);
      chk("midrst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("midrst_rsp_data", 32'(bus.rsp_data), 32'h044);
      next_cycle();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
